// File: rtl/cnn_conv_sequencer.sv
// Sequencer for the KxK convolution datapath: fetches taps, accumulates, quantises, writes results.
// Optional CNN_SEQ_RELU_EN clamps negative quantised results to zero before saturation.
module cnn_conv_sequencer #(
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int K     = 3,
    parameter int AW    = 8,
    parameter int ACC_W = 20,
    parameter int SHIFT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          img_re,
    output logic [AW-1:0] img_addr,
    input  logic [7:0]    pix_data,
    output logic [AW-1:0] w_addr,
    input  logic [7:0]    w_data,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [7:0]    res_data,
    output logic [7:0]    Res_reg
);

    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam logic [AW-1:0] KM1  = AW'(K - 1);
    localparam logic [AW-1:0] OWM1 = AW'(OW - 1);
    localparam logic [AW-1:0] OHM1 = AW'(OH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    state_t                   state;
    logic [AW-1:0]            ox, oy, kx, ky;
    logic                     valid;
    logic signed [ACC_W-1:0]  acc;

    logic signed [16:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [7:0]               q;
    logic [AW-1:0]            next_kx, next_ky, next_ox, next_oy;
    logic                     last_tap, last_out;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                               input logic [AW-1:0] tx, input logic [AW-1:0] ty);
        return AW'((32'(y) + 32'(ty)) * 32'(IMG_W) + 32'(x) + 32'(tx));
    endfunction

    function automatic logic [AW-1:0] lin_addr(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                               input int unsigned stride);
        return AW'(32'(y) * stride + 32'(x));
    endfunction

    always_comb begin
        prod     = $signed({1'b0, pix_data}) * $signed(w_data);
        prod_ext = {{(ACC_W-17){prod[16]}}, prod};
        acc_sum  = valid ? acc + prod_ext : acc;
        shifted  = acc_sum >>> SHIFT;
`ifdef CNN_SEQ_RELU_EN
        if (shifted[ACC_W-1])
            q = '0;
        else if (|shifted[ACC_W-2:7])
            q = 8'h7F;
        else
            q = shifted[7:0];
`else
        if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:7]))
            q = 8'h7F;
        else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:7]))
            q = 8'h80;
        else
            q = shifted[7:0];
`endif
        last_tap = (kx == KM1) && (ky == KM1);
        next_kx  = (kx == KM1) ? '0 : kx + 1'b1;
        next_ky  = (kx == KM1) ? ky + 1'b1 : ky;
        last_out = (ox == OWM1) && (oy == OHM1);
        next_ox  = (ox == OWM1) ? '0 : ox + 1'b1;
        next_oy  = (ox == OWM1) ? oy + 1'b1 : oy;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ox       <= '0;
            oy       <= '0;
            kx       <= '0;
            ky       <= '0;
            acc      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            img_re   <= 1'b0;
            img_addr <= '0;
            w_addr   <= '0;
            res_we   <= 1'b0;
            res_addr <= '0;
            res_data <= '0;
            Res_reg  <= '0;
        end else begin
            valid  <= img_re;
            img_re <= 1'b0;
            res_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        ox       <= '0;
                        oy       <= '0;
                        kx       <= '0;
                        ky       <= '0;
                        acc      <= '0;
                        img_re   <= 1'b1;
                        img_addr <= '0;
                        w_addr   <= '0;
                    end
                end
                FETCH: begin
                    acc <= acc_sum;
                    if (last_tap) begin
                        state <= DRAIN;
                    end else begin
                        kx       <= next_kx;
                        ky       <= next_ky;
                        img_re   <= 1'b1;
                        img_addr <= pix_addr(ox, oy, next_kx, next_ky);
                        w_addr   <= lin_addr(next_kx, next_ky, K);
                    end
                end
                // The quantised value is registered here so the write strobe,
                // data and Res_reg all appear together during WRITE.
                DRAIN: begin
                    acc      <= acc_sum;
                    res_we   <= 1'b1;
                    res_data <= q;
                    Res_reg  <= q;
                    res_addr <= lin_addr(ox, oy, OW);
                    state    <= WRITE;
                end
                WRITE: begin
                    ox <= next_ox;
                    oy <= next_oy;
                    if (last_out) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        kx       <= '0;
                        ky       <= '0;
                        acc      <= '0;
                        img_re   <= 1'b1;
                        img_addr <= pix_addr(next_ox, next_oy, '0, '0);
                        w_addr   <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Self-checking bench for cnn_conv_sequencer: memory models, a frame-level reference
// model and a per-cycle comparator, plus literal expectations for directed frames.
module tb_cnn_conv_sequencer;

    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int K     = 3;
    localparam int AW    = 8;
    localparam int SH    = 4;
    localparam int OW    = IMG_W - K + 1;
    localparam int OH    = IMG_H - K + 1;
    localparam int NOUT  = OW * OH;
    localparam int PER   = K * K + 2;
    localparam int FRAME = NOUT * PER;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, img_re, res_we;
    logic [AW-1:0] img_addr, w_addr, res_addr;
    logic [7:0]    pix_data = '0;
    logic [7:0]    w_data = '0;
    logic [7:0]    res_data, Res_reg;

    cnn_conv_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .AW(AW), .ACC_W(20), .SHIFT(SH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .img_re(img_re), .img_addr(img_addr), .pix_data(pix_data),
        .w_addr(w_addr), .w_data(w_data), .res_we(res_we), .res_addr(res_addr),
        .res_data(res_data), .Res_reg(Res_reg)
    );

    always #5 clock = ~clock;

    logic [7:0]        img [IMG_W*IMG_H];
    logic signed [7:0] wt  [K*K];

    // Synchronous-read memories; garbage is returned when not enabled.
    always @(posedge clock) begin
        if (img_re) begin
            pix_data <= img[img_addr];
            w_data   <= wt[w_addr];
        end else begin
            pix_data <= 8'($urandom);
            w_data   <= 8'($urandom);
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] ref_out(input int ox, input int oy);
        int sum = 0;
        int q;
        for (int ty = 0; ty < K; ty++)
            for (int tx = 0; tx < K; tx++)
                sum += int'(img[(oy + ty) * IMG_W + ox + tx]) * int'(wt[ty * K + tx]);
        q = sum >>> SH;
`ifdef CNN_SEQ_RELU_EN
        if (q < 0) q = 0;
`endif
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    // Frame-level model: a frame is the FRAME+1 cycles following an accepted start.
    int         cyc = 0;
    int         fs = 0;
    bit         active = 1'b0;
    logic [7:0] exp_res [NOUT];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            active = 1'b0;
        end else begin
            cyc++;
            if (active && (cyc - fs == FRAME + 1)) begin
                active = 1'b0;
            end else if (!active && start) begin
                active = 1'b1;
                fs = cyc;
                for (int o = 0; o < NOUT; o++) exp_res[o] = ref_out(o % OW, o / OW);
            end
        end
    end

    logic [7:0] held = '0;
    int         writes_seen = 0;
    int         done_seen = 0;
    int         done_d = -1;

    always @(negedge clock) begin
        int d, j, t, ox, oy;
        logic e_busy, e_done, e_re, e_we;
        e_busy = 1'b0; e_done = 1'b0; e_re = 1'b0; e_we = 1'b0;
        d = 0; j = 0; t = 0;
        if (!reset) begin
            held = '0;
        end else if (active) begin
            d = cyc - fs;
            if (d < FRAME) begin
                e_busy = 1'b1;
                j = d / PER;
                t = d % PER;
                e_re = (t < K * K);
                e_we = (t == PER - 1);
            end else if (d == FRAME) begin
                e_done = 1'b1;
            end
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("img_re", 32'(img_re), 32'(e_re));
        chk("res_we", 32'(res_we), 32'(e_we));
        if (e_re) begin
            ox = j % OW;
            oy = j / OW;
            chk("img_addr", 32'(img_addr), 32'((oy + t / K) * IMG_W + ox + t % K));
            chk("w_addr", 32'(w_addr), 32'(t));
        end
        if (e_we) begin
            held = exp_res[j];
            chk("res_addr", 32'(res_addr), 32'(j));
            chk("res_data", 32'(res_data), 32'(exp_res[j]));
        end
        chk("Res_reg", 32'(Res_reg), 32'(held));
        if (res_we) writes_seen++;
        if (done) begin
            done_seen++;
            done_d = cyc - fs;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic fill(input int p, input int w);
        for (int i = 0; i < IMG_W * IMG_H; i++) img[i] = 8'(p);
        for (int i = 0; i < K * K; i++) wt[i] = 8'(w);
    endtask

    task automatic fill_rand(input bit small_w);
        for (int i = 0; i < IMG_W * IMG_H; i++) img[i] = 8'($urandom);
        for (int i = 0; i < K * K; i++)
            wt[i] = small_w ? 8'(int'($urandom_range(0, 8)) - 4) : 8'($urandom);
    endtask

    // lit < 0 means no literal expectation; poke pulses start during output 5.
    task automatic run_frame(input string nm, input int lit, input bit poke);
        bit got;
        got = 1'b0;
        writes_seen = 0;
        done_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            start = (poke && (i == 5 * PER + 2));
            if (done_seen != 0) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) tick();
        chk({nm, "_writes"}, 32'(writes_seen), 32'(NOUT));
        chk({nm, "_done_count"}, 32'(done_seen), 32'd1);
        chk({nm, "_done_latency"}, 32'(done_d), 32'd176);
        if (lit >= 0) begin
            chk({nm, "_model_pin"}, 32'(exp_res[NOUT-1]), 32'(lit));
            chk({nm, "_Res_reg"}, 32'(Res_reg), 32'(lit));
        end
    endtask

    initial begin
        fill(0, 0);
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_Res_reg", 32'(Res_reg), 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        fill(16, 1);
        run_frame("ones", 9, 1'b0);          // 9*16 = 144 >>> 4 = 9
        fill(100, 1);
        run_frame("pix100", 56, 1'b0);       // 900 >>> 4 = 56
        fill(255, 127);
        run_frame("sat_hi", 127, 1'b0);      // 291465 >>> 4 saturates
        fill(10, -1);
`ifdef CNN_SEQ_RELU_EN
        run_frame("neg", 0, 1'b0);
`else
        run_frame("neg", 8'hFA, 1'b0);       // -90 >>> 4 = -6
`endif
        fill_rand(1'b0);
        run_frame("rand_poke", -1, 1'b1);
        fill_rand(1'b1);
        run_frame("rand_small", -1, 1'b0);

        // Abort during output 7 fetch.
        fill_rand(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7 * PER + 3) tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_we", 32'(res_we), 32'd0);
        chk("abort_Res_reg", 32'(Res_reg), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        run_frame("after_abort", -1, 1'b0);

        // Start held high across two frames: back-to-back with one IDLE cycle.
        fill_rand(1'b1);
        writes_seen = 0;
        done_seen = 0;
        start = 1'b1;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            if (done_seen >= 2) break;
        end
        start = 1'b0;
        chk("held_done_count", 32'(done_seen), 32'd2);
        chk("held_writes", 32'(writes_seen), 32'(2 * NOUT));
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
